// File: rtl/reg_arbiter_pkg.sv
// Shared types and default constants for the round-robin shared-register arbiter.
package reg_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    localparam int DEF_N_REQ    = 4;
    localparam int DEF_DATA_W   = 8;
    localparam int DEF_MAX_HOLD = 4;

    // Width needed to index n items, never less than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/reg_arbiter_rr_pick.sv
// Combinational round-robin picker: first masked request strictly after ptr, with wrap-around.
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req_i,
    input  logic [N-1:0]     mask_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic             any_o
);

    logic [IDX_W-1:0] idx;

    always_comb begin
        gnt_o = '0;
        any_o = 1'b0;
        idx   = '0;
        // k runs 1..N so the current holder (ptr) is considered last.
        for (int k = 1; k <= N; k++) begin
            idx = IDX_W'((int'(ptr_i) + k) % N);
            if (!any_o && req_i[idx] && mask_i[idx]) begin
                gnt_o[idx] = 1'b1;
                any_o      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_arbiter.sv
// Round-robin arbiter granting writes to one shared register with bounded tenure.
// Optional REG_ARBITER_LOCK_EN adds a lock input that suppresses tenure expiry.
module reg_arbiter
    import reg_arbiter_pkg::*;
#(
    parameter int N_REQ    = DEF_N_REQ,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DATA_W-1:0]   wdata,
`ifdef REG_ARBITER_LOCK_EN
    input  logic [N_REQ-1:0]          lock,
`endif
    output logic [N_REQ-1:0]          gnt,
    output logic [DATA_W-1:0]         q,
    output logic                      q_valid,
    output logic                      busy
);

    localparam int IDX_W = idx_w(N_REQ);
    localparam int CNT_W = idx_w(MAX_HOLD);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
    localparam logic [IDX_W-1:0] PTR_RST   = IDX_W'(N_REQ - 1);

    state_e             state_q, state_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [DATA_W-1:0]  q_q, q_d;
    logic               q_valid_q, q_valid_d;
    logic [CNT_W-1:0]   hold_q, hold_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;

    logic [N_REQ-1:0]   pick_mask, pick_gnt;
    logic               pick_any;
    logic [IDX_W-1:0]   pick_idx;
    logic [DATA_W-1:0]  cur_data;
    logic               cur_req, locked, at_last;

    // The holder is masked out so expiry hands off; on release its req is already 0.
    assign pick_mask = (state_q == GRANT) ? ~gnt_q : {N_REQ{1'b1}};
    assign cur_req   = |(gnt_q & req);
    assign at_last   = (hold_q == HOLD_LAST);

`ifdef REG_ARBITER_LOCK_EN
    assign locked = |(gnt_q & req & lock);
`else
    assign locked = 1'b0;
`endif

    rr_pick #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i  (req),
        .mask_i (pick_mask),
        .ptr_i  (ptr_q),
        .gnt_o  (pick_gnt),
        .any_o  (pick_any)
    );

    always_comb begin
        cur_data = '0;
        pick_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_q[i])    cur_data = wdata[i*DATA_W +: DATA_W];
            if (pick_gnt[i]) pick_idx = IDX_W'(i);
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        q_d       = q_q;
        q_valid_d = 1'b0;
        hold_d    = hold_q;
        ptr_d     = ptr_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d = GRANT;
                    gnt_d   = pick_gnt;
                    ptr_d   = pick_idx;
                    hold_d  = '0;
                end
            end
            GRANT: begin
                if (cur_req) begin
                    q_d       = cur_data;
                    q_valid_d = 1'b1;
                    if (at_last && !locked) begin
                        // With no competitor the holder keeps gnt and starts a fresh tenure.
                        hold_d = '0;
                        if (pick_any) begin
                            gnt_d = pick_gnt;
                            ptr_d = pick_idx;
                        end
                    end else if (!at_last) begin
                        hold_d = hold_q + 1'b1;
                    end
                end else begin
                    hold_d = '0;
                    if (pick_any) begin
                        gnt_d = pick_gnt;
                        ptr_d = pick_idx;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            q_q       <= '0;
            q_valid_q <= 1'b0;
            hold_q    <= '0;
            ptr_q     <= PTR_RST;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            q_q       <= q_d;
            q_valid_q <= q_valid_d;
            hold_q    <= hold_d;
            ptr_q     <= ptr_d;
        end
    end

    assign gnt     = gnt_q;
    assign q       = q_q;
    assign q_valid = q_valid_q;
    assign busy    = (state_q == GRANT);

endmodule
